// File: rtl/cnn_layer_accel_octo.sv
// CNN layer accelerator octo: sequence table and pixel row-buffer loader
// plus the read sequencer that feeds the array window engines.
module cnn_layer_accel_octo_bram_ctrl #(
   parameter int C_NUM_AWE        = 4,
   parameter int C_PIXEL_WIDTH    = 16,
   parameter int C_BRAM_DEPTH     = 1024,
   parameter int C_SEQ_DATA_WIDTH = 13
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     new_map_i,
   input  logic                     pixel_datain_tag_i,
   output logic                     pixel_datain_rdy_o,
   input  logic                     seq_datain_tag_i,
   output logic                     seq_datain_rdy_o,
   input  logic [C_PIXEL_WIDTH-1:0] datain_i,
   input  logic                     datain_valid_i
);
   localparam int AW = $clog2(C_BRAM_DEPTH);
   localparam int TD = 1024;

   typedef enum logic [1:0] {IDLE, SEQ_LOAD, PIX_LOAD} state_t;

   logic [9:0]  num_input_rows_cfg;
   logic [9:0]  num_input_cols_cfg;
   logic [9:0]  num_output_rows_cfg;
   logic [9:0]  num_output_cols_cfg;
   logic [10:0] seq_full_count_cfg;
   logic [9:0]  row_matric_done_count_cfg;

   state_t state_q, state_d;

   logic [C_SEQ_DATA_WIDTH-1:0] seq_tbl [TD];
   logic [C_PIXEL_WIDTH-1:0]    pix_mem [C_BRAM_DEPTH];

   logic [10:0] seq_count_q;
   logic [9:0]  col_q;
   logic [1:0]  slot_q;
   logic [1:0]  base_q;
   logic [2:0]  rows_stored_q;
   logic [20:0] pix_loaded_q;
   logic [10:0] output_row_q;
   logic [9:0]  rd_idx_q;
   logic        rd_wait_q;
   logic [9:0]  rd_cnt_q;

   logic [C_NUM_AWE-1:0]     awe_en_q;
   logic [C_PIXEL_WIDTH-1:0] awe_pix_q;
   logic                     awe_first_q;
   logic                     awe_last_q;
   logic                     win_open_q;

   logic        map_start, clr;
   logic        seq_acc, seq_done;
   logic        pix_acc, last_col;
   logic        rd_step, rd_last, row_free, maps_done;
   logic [20:0] rows_p1, cols_p1, pix_total;
   logic [1:0]  rd_slot;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [C_SEQ_DATA_WIDTH-1:0] rd_word;

   assign rows_p1   = 21'(num_input_rows_cfg) + 21'd1;
   assign cols_p1   = 21'(num_input_cols_cfg) + 21'd1;
   assign pix_total = rows_p1 * cols_p1;

   assign map_start = (state_q == IDLE) && new_map_i;
   assign clr       = rst || map_start;

   assign seq_datain_rdy_o = (state_q == SEQ_LOAD) &&
                             (seq_count_q < seq_full_count_cfg);
   assign seq_acc  = datain_valid_i && seq_datain_tag_i &&
                     seq_datain_rdy_o;
   assign seq_done = seq_acc ?
                     (seq_count_q + 11'd1 >= seq_full_count_cfg) :
                     (seq_count_q >= seq_full_count_cfg);

   assign pixel_datain_rdy_o = (state_q == PIX_LOAD) &&
                               (rows_stored_q < 3'd4) &&
                               (pix_loaded_q < pix_total);
   assign pix_acc  = datain_valid_i && pixel_datain_tag_i &&
                     pixel_datain_rdy_o;
   assign last_col = (col_q == num_input_cols_cfg);
   assign wr_addr  = AW'(21'(slot_q) * cols_p1 + 21'(col_q));

   // Engine walks the table once three rows are resident, then drains
   assign rd_step   = (state_q == PIX_LOAD) && !rd_wait_q &&
                      (rows_stored_q >= 3'd3);
   assign rd_last   = ({1'b0, rd_idx_q} + 11'd1 >= seq_full_count_cfg);
   assign row_free  = (state_q == PIX_LOAD) && rd_wait_q &&
                      (rd_cnt_q == row_matric_done_count_cfg);
   assign maps_done = row_free &&
                      (output_row_q >= {1'b0, num_output_rows_cfg});

   assign rd_word = seq_tbl[rd_idx_q];
   assign rd_slot = base_q + {1'b0, rd_word[10]};
   assign rd_addr = AW'(21'(rd_slot) * cols_p1 + 21'(rd_word[9:0]));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (new_map_i) state_d = SEQ_LOAD;
         SEQ_LOAD: if (seq_done)  state_d = PIX_LOAD;
         PIX_LOAD: if (maps_done) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         seq_count_q   <= '0;
         col_q         <= '0;
         slot_q        <= '0;
         base_q        <= '0;
         rows_stored_q <= '0;
         pix_loaded_q  <= '0;
         output_row_q  <= '0;
         rd_idx_q      <= '0;
         rd_wait_q     <= 1'b0;
         rd_cnt_q      <= '0;
         awe_en_q      <= '0;
         awe_pix_q     <= '0;
         awe_first_q   <= 1'b0;
         awe_last_q    <= 1'b0;
         win_open_q    <= 1'b0;
      end else begin
         if (seq_acc) seq_count_q <= seq_count_q + 11'd1;
         if (pix_acc) begin
            pix_loaded_q <= pix_loaded_q + 21'd1;
            col_q        <= last_col ? 10'd0 : col_q + 10'd1;
            if (last_col) slot_q <= slot_q + 2'd1;
         end
         case ({pix_acc && last_col, row_free})
            2'b10:   rows_stored_q <= rows_stored_q + 3'd1;
            2'b01:   rows_stored_q <= rows_stored_q - 3'd1;
            default: rows_stored_q <= rows_stored_q;
         endcase
         if (rd_step) begin
            rd_idx_q  <= rd_last ? 10'd0 : rd_idx_q + 10'd1;
            rd_wait_q <= rd_last;
            rd_cnt_q  <= '0;
         end else if (rd_wait_q) begin
            rd_cnt_q <= rd_cnt_q + 10'd1;
            if (row_free) begin
               rd_wait_q    <= 1'b0;
               base_q       <= base_q + 2'd1;
               output_row_q <= output_row_q + 11'd1;
            end
         end
         awe_en_q    <= {C_NUM_AWE{rd_step}};
         awe_pix_q   <= pix_mem[rd_addr];
         awe_first_q <= rd_step && rd_word[11];
         awe_last_q  <= rd_step && rd_word[12];
         if (rd_step && rd_word[11])      win_open_q <= 1'b1;
         else if (rd_step && rd_word[12]) win_open_q <= 1'b0;
      end
   end

   // Storage is never cleared; a reset edge only blocks the write
   always_ff @(posedge clk) begin
      if (!rst && seq_acc)
         seq_tbl[seq_count_q[9:0]] <= datain_i[C_SEQ_DATA_WIDTH-1:0];
      if (!rst && pix_acc)
         pix_mem[wr_addr] <= datain_i;
   end
endmodule

module cnn_layer_accel_octo #(
   parameter int C_NUM_AWE        = 4,
   parameter int C_PIXEL_WIDTH    = 16,
   parameter int C_BRAM_DEPTH     = 1024,
   parameter int C_SEQ_DATA_WIDTH = 13
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pixel_datain_tag,
   output logic                     pixel_datain_rdy,
   input  logic                     seq_datain_tag,
   output logic                     seq_datain_rdy,
   input  logic [C_PIXEL_WIDTH-1:0] datain,
   input  logic                     datain_valid
);
   logic new_map;

   cnn_layer_accel_octo_bram_ctrl #(
      .C_NUM_AWE        (C_NUM_AWE),
      .C_PIXEL_WIDTH    (C_PIXEL_WIDTH),
      .C_BRAM_DEPTH     (C_BRAM_DEPTH),
      .C_SEQ_DATA_WIDTH (C_SEQ_DATA_WIDTH)
   ) i0_cnn_layer_accel_octo_bram_ctrl (
      .clk                (clk),
      .rst                (rst),
      .new_map_i          (new_map),
      .pixel_datain_tag_i (pixel_datain_tag),
      .pixel_datain_rdy_o (pixel_datain_rdy),
      .seq_datain_tag_i   (seq_datain_tag),
      .seq_datain_rdy_o   (seq_datain_rdy),
      .datain_i           (datain),
      .datain_valid_i     (datain_valid)
   );
endmodule

// File: tb/tb_cnn_layer_accel_octo.sv
// Randomized bench for cnn_layer_accel_octo: 10x10 map, 3x3 kernel,
// 40-entry sequence table, checked against a row-level timing model.
module tb_cnn_layer_accel_octo;
   localparam int PW    = 16;
   localparam int NSEQ  = 40;
   localparam int COLS  = 10;
   localparam int NPIX  = 100;
   localparam int DONE  = 1;
   localparam int PASS  = NSEQ + DONE + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          pixel_datain_tag;
   logic          pixel_datain_rdy;
   logic          seq_datain_tag;
   logic          seq_datain_rdy;
   logic [PW-1:0] datain;
   logic          datain_valid;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   logic [12:0]   seqw [NSEQ];
   logic [PW-1:0] pix  [NPIX];

   cnn_layer_accel_octo dut (
      .clk              (clk),
      .rst              (rst),
      .pixel_datain_tag (pixel_datain_tag),
      .pixel_datain_rdy (pixel_datain_rdy),
      .seq_datain_tag   (seq_datain_tag),
      .seq_datain_rdy   (seq_datain_rdy),
      .datain           (datain),
      .datain_valid     (datain_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic pulse_map();
      dut.new_map = 1'b1;
      tick();
      dut.new_map = 1'b0;
   endtask

   task automatic load_seq();
      int  acc;
      logic v, wrong;
      acc = 0;
      for (int i = 0; i < NSEQ; i++) seqw[i] = 13'($urandom);
      seqw[0] = {1'b0, 1'b1, 1'b1, 10'd0};
      seqw[4] = {1'b1, 1'b0, 1'b0, 10'd514};
      for (int t = 0; t < 400 && acc < NSEQ; t++) begin
         v     = ($urandom_range(0, 3) != 0);
         wrong = ($urandom_range(0, 7) == 0);
         datain_valid     = v;
         seq_datain_tag   = !wrong;
         pixel_datain_tag = wrong;
         datain = wrong ? PW'($urandom) : PW'(seqw[acc]);
         chk("seq_rdy", seq_datain_rdy, acc < NSEQ);
         if (v && !wrong) acc++;
         tick();
      end
      datain_valid     = 1'b0;
      seq_datain_tag   = 1'b0;
      pixel_datain_tag = 1'b0;
      chk("seq_accepted", acc, NSEQ);
      chk("seq_rdy_off", seq_datain_rdy, 0);
      for (int i = 0; i < NSEQ; i++)
         chk("seq_tbl", dut.i0_cnn_layer_accel_octo_bram_ctrl.seq_tbl[i],
             seqw[i]);
   endtask

   initial begin
      int   pacc;
      int   start;
      logic v, wrong;

      rst              = 1'b1;
      pixel_datain_tag = 1'b0;
      seq_datain_tag   = 1'b0;
      datain           = '0;
      datain_valid     = 1'b0;
      dut.new_map      = 1'b0;
      dut.i0_cnn_layer_accel_octo_bram_ctrl.num_input_rows_cfg = 10'd9;
      dut.i0_cnn_layer_accel_octo_bram_ctrl.num_input_cols_cfg = 10'd9;
      dut.i0_cnn_layer_accel_octo_bram_ctrl.num_output_rows_cfg = 10'd7;
      dut.i0_cnn_layer_accel_octo_bram_ctrl.num_output_cols_cfg = 10'd7;
      dut.i0_cnn_layer_accel_octo_bram_ctrl.seq_full_count_cfg = 11'(NSEQ);
      dut.i0_cnn_layer_accel_octo_bram_ctrl.row_matric_done_count_cfg =
         10'(DONE);
      for (int i = 0; i < NPIX; i++) pix[i] = PW'($urandom_range(1, 10));

      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("rst_seq_rdy", seq_datain_rdy, 0);
      chk("rst_pix_rdy", pixel_datain_rdy, 0);
      chk("rst_rows",
          dut.i0_cnn_layer_accel_octo_bram_ctrl.rows_stored_q, 0);
      tick();
      chk("idle_no_map", seq_datain_rdy, 0);

      pulse_map();
      chk("map_seq_rdy", seq_datain_rdy, 1);
      chk("map_pix_rdy", pixel_datain_rdy, 0);
      load_seq();
      chk("pix_rdy_on", pixel_datain_rdy, 1);

      // First four rows stream in back to back
      pacc  = 0;
      start = -1;
      pixel_datain_tag = 1'b1;
      datain_valid     = 1'b1;
      for (int t = 0; t < 80 && pacc < 4 * COLS; t++) begin
         datain = pix[pacc];
         chk("pix_rdy_hold", pixel_datain_rdy, 1);
         if (pacc == 29)
            chk("eng_idle", dut.i0_cnn_layer_accel_octo_bram_ctrl.rd_step, 0);
         if (pacc == 30 && start < 0) begin
            chk("eng_start",
                dut.i0_cnn_layer_accel_octo_bram_ctrl.rd_step, 1);
            start = cyc;
         end
         if (pixel_datain_rdy) pacc++;
         tick();
      end
      chk("pix_first40", pacc, 4 * COLS);
      chk("pix_rdy_full", pixel_datain_rdy, 0);
      chk("rows_full",
          dut.i0_cnn_layer_accel_octo_bram_ctrl.rows_stored_q, 4);
      for (int k = 0; k < 4 * COLS; k++)
         chk("buf_head", dut.i0_cnn_layer_accel_octo_bram_ctrl.pix_mem[k],
             pix[k]);

      pulse_map();
      chk("map_ignored", seq_datain_rdy, 0);

      // A full table pass plus the drain wait frees the oldest row
      datain = pix[pacc];
      for (int t = 0; t < 80; t++) begin
         if (pixel_datain_rdy) break;
         tick();
      end
      chk("rdy_return_lat", cyc - start, PASS);

      for (int t = 0; t < 3000; t++) begin
         if (dut.i0_cnn_layer_accel_octo_bram_ctrl.output_row_q == 11'd8)
            break;
         datain_valid = (pacc < NPIX);
         datain       = (pacc < NPIX) ? pix[pacc] : '0;
         if (datain_valid && pixel_datain_rdy) pacc++;
         tick();
      end
      datain_valid = 1'b0;
      chk("all_pix", pacc, NPIX);
      chk("out_rows",
          dut.i0_cnn_layer_accel_octo_bram_ctrl.output_row_q, 8);
      chk("done_pix_rdy", pixel_datain_rdy, 0);
      chk("done_seq_rdy", seq_datain_rdy, 0);
      for (int r = 6; r < 10; r++)
         for (int c = 0; c < COLS; c++)
            chk("buf_tail",
                dut.i0_cnn_layer_accel_octo_bram_ctrl.pix_mem[(r % 4) * COLS + c],
                pix[r * COLS + c]);

      // Second map: gappy traffic, then reset part way through the rows
      pixel_datain_tag = 1'b0;
      pulse_map();
      chk("remap_seq_rdy", seq_datain_rdy, 1);
      load_seq();
      pacc = 0;
      for (int t = 0; t < 200 && pacc < 20; t++) begin
         v     = ($urandom_range(0, 2) != 0);
         wrong = ($urandom_range(0, 5) == 0);
         datain_valid     = v;
         pixel_datain_tag = !wrong;
         seq_datain_tag   = wrong;
         datain = wrong ? PW'($urandom) : pix[pacc];
         chk("pix_rdy_r2", pixel_datain_rdy, 1);
         if (v && !wrong && pixel_datain_rdy) pacc++;
         tick();
      end
      datain_valid     = 1'b0;
      pixel_datain_tag = 1'b0;
      seq_datain_tag   = 1'b0;
      chk("pix_r2_count", pacc, 20);
      chk("rows_r2",
          dut.i0_cnn_layer_accel_octo_bram_ctrl.rows_stored_q, 2);
      for (int k = 0; k < 20; k++)
         chk("buf_r2", dut.i0_cnn_layer_accel_octo_bram_ctrl.pix_mem[k],
             pix[k]);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_pix_rdy", pixel_datain_rdy, 0);
      chk("abort_seq_rdy", seq_datain_rdy, 0);
      chk("abort_rows",
          dut.i0_cnn_layer_accel_octo_bram_ctrl.rows_stored_q, 0);
      chk("abort_loaded",
          dut.i0_cnn_layer_accel_octo_bram_ctrl.pix_loaded_q, 0);
      chk("abort_seq_cnt",
          dut.i0_cnn_layer_accel_octo_bram_ctrl.seq_count_q, 0);
      tick();
      chk("abort_idle", seq_datain_rdy, 0);
      for (int i = 0; i < NSEQ; i++)
         chk("tbl_kept", dut.i0_cnn_layer_accel_octo_bram_ctrl.seq_tbl[i],
             seqw[i]);
      pulse_map();
      chk("restart_seq_rdy", seq_datain_rdy, 1);
      chk("restart_seq_cnt",
          dut.i0_cnn_layer_accel_octo_bram_ctrl.seq_count_q, 0);
      chk("restart_pix_rdy", pixel_datain_rdy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
